// File: rtl/counter_pkg.sv
// Shared encodings for the bounded up/down counter: count mode and direction.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_updown_bounded_nbit.sv
// Up/down counter bounded to a programmable [min_val, max_val] window with wrap or
// saturate mode, a terminal-count pulse and a sticky overflow flag.
module counter_updown_bounded_nbit
  import counter_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic [CNT_WIDTH-1:0]  load_val,
  input  logic                  en,
  input  logic                  up_down,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  mode,
  input  logic [CNT_WIDTH-1:0]  min_val,
  input  logic [CNT_WIDTH-1:0]  max_val,
  input  logic                  ovf_clr,
  output logic [CNT_WIDTH-1:0]  counter_out,
  output logic                  at_min,
  output logic                  at_max,
  output logic                  tc_pulse,
  output logic                  ovf_sticky,
  output logic                  cfg_err
);

  localparam int EXT_W = CNT_WIDTH + 1;

  logic [CNT_WIDTH-1:0] counter_r;
  logic                 tc_r;
  logic                 ovf_r;

  logic [CNT_WIDTH-1:0] next_cnt_s;
  logic                 event_s;
  logic                 ovf_next_s;
  logic                 cfg_err_s;
  logic                 in_window_s;
  logic [EXT_W-1:0]     step_ext_s;
  logic [EXT_W-1:0]     cnt_ext_s;
  logic [EXT_W-1:0]     min_ext_s;
  logic [EXT_W-1:0]     max_ext_s;
  logic [EXT_W-1:0]     sum_s;
  logic [EXT_W-1:0]     diff_s;

  assign cfg_err_s   = (min_val > max_val);
  assign in_window_s = (counter_r >= min_val) && (counter_r <= max_val);
  assign step_ext_s  = {{(EXT_W - STEP_WIDTH){1'b0}}, step};
  assign cnt_ext_s   = {1'b0, counter_r};
  assign min_ext_s   = {1'b0, min_val};
  assign max_ext_s   = {1'b0, max_val};
  // The extra top bit catches carry out of the top and borrow below zero.
  assign sum_s       = cnt_ext_s + step_ext_s;
  assign diff_s      = cnt_ext_s - step_ext_s;

  // Next count and bound-crossing detection, in edge priority order.
  always_comb begin
    next_cnt_s = counter_r;
    event_s    = 1'b0;
    if (cfg_err_s) begin
      next_cnt_s = counter_r;
    end else if (clear) begin
      next_cnt_s = min_val;
    end else if (load_en) begin
      if (load_val < min_val) begin
        next_cnt_s = min_val;
      end else if (load_val > max_val) begin
        next_cnt_s = max_val;
      end else begin
        next_cnt_s = load_val;
      end
    end else if (en && (step != {STEP_WIDTH{1'b0}})) begin
      if (!in_window_s) begin
        next_cnt_s = (up_down == DIR_UP) ? min_val : max_val;
      end else if (up_down == DIR_UP) begin
        if (sum_s > max_ext_s) begin
          event_s    = 1'b1;
          next_cnt_s = (mode == MODE_SAT) ? max_val : min_val;
        end else begin
          next_cnt_s = sum_s[CNT_WIDTH-1:0];
        end
      end else begin
        if (diff_s[CNT_WIDTH] || (diff_s < min_ext_s)) begin
          event_s    = 1'b1;
          next_cnt_s = (mode == MODE_SAT) ? min_val : max_val;
        end else begin
          next_cnt_s = diff_s[CNT_WIDTH-1:0];
        end
      end
    end else begin
      next_cnt_s = counter_r;
    end
  end

  // A new crossing wins over a simultaneous clear request.
  always_comb begin
    if (event_s) begin
      ovf_next_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Count, terminal-count pulse and sticky overflow state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_r <= {CNT_WIDTH{1'b0}};
      tc_r      <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      counter_r <= next_cnt_s;
      tc_r      <= event_s;
      ovf_r     <= ovf_next_s;
    end
  end

  assign counter_out = counter_r;
  assign tc_pulse    = tc_r;
  assign ovf_sticky  = ovf_r;
  assign at_min      = (counter_r == min_val);
  assign at_max      = (counter_r == max_val);
  assign cfg_err     = cfg_err_s;

endmodule : counter_updown_bounded_nbit

// File: tb/tb_counter_updown_bounded_nbit.sv
// Directed self-checking bench for counter_updown_bounded_nbit at CNT_WIDTH=4, STEP_WIDTH=2.
module tb_counter_updown_bounded_nbit;

  localparam int CW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear, load_en, en, up_down, mode, ovf_clr;
  logic [CW-1:0] load_val, min_val, max_val;
  logic [SW-1:0] step;
  logic [CW-1:0] counter_out;
  logic          at_min, at_max, tc_pulse, ovf_sticky, cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  counter_updown_bounded_nbit #(.CNT_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_en(load_en), .load_val(load_val),
    .en(en), .up_down(up_down), .step(step), .mode(mode), .min_val(min_val),
    .max_val(max_val), .ovf_clr(ovf_clr), .counter_out(counter_out), .at_min(at_min),
    .at_max(at_max), .tc_pulse(tc_pulse), .ovf_sticky(ovf_sticky), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; load_en = 1'b0; en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_inputs();
    load_val = 4'd0; up_down = 1'b1; step = 2'd1; mode = 1'b0;
    min_val = 4'd0; max_val = 4'd15;
    #3;
    tests_run++;
    if (counter_out !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", counter_out); end
    tests_run++;
    if (tc_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: tc=%b ovf=%b want 0 0", tc_pulse, ovf_sticky);
    end
    tests_run++;
    if (cfg_err !== 1'b0 || at_min !== 1'b1) begin
      tests_failed++; $display("FAIL reset_cmp: cfg_err=%b at_min=%b want 0 1", cfg_err, at_min);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    min_val = 4'd2; max_val = 4'd9; step = 2'd1; up_down = 1'b1; mode = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    tests_run++;
    if (counter_out !== 4'd2 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL clear_min: got %0d tc=%b want 2 0", counter_out, tc_pulse);
    end
    en = 1'b1;
    for (int v = 3; v <= 9; v++) begin
      tick();
      tests_run++;
      if (counter_out !== v[CW-1:0] || tc_pulse !== 1'b0) begin
        tests_failed++; $display("FAIL up_step: got %0d tc=%b want %0d 0", counter_out, tc_pulse, v);
      end
    end
    tests_run++;
    if (at_max !== 1'b1 || ovf_sticky !== 1'b0) begin
      tests_failed++; $display("FAIL at_max9: at_max=%b ovf=%b want 1 0", at_max, ovf_sticky);
    end
    tick();
    tests_run++;
    if (counter_out !== 4'd2 || tc_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_wrap: got %0d tc=%b ovf=%b want 2 1 1", counter_out, tc_pulse, ovf_sticky);
    end
    en = 1'b0; tick();
    tests_run++;
    if (tc_pulse !== 1'b0 || ovf_sticky !== 1'b1 || counter_out !== 4'd2) begin
      tests_failed++;
      $display("FAIL tc_one_cycle: got %0d tc=%b ovf=%b want 2 0 1", counter_out, tc_pulse, ovf_sticky);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tests_run++;
    if (ovf_sticky !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_saturate();
    mode = 1'b1; step = 2'd3; up_down = 1'b1;
    load_val = 4'd8; load_en = 1'b1; tick(); load_en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd8) begin tests_failed++; $display("FAIL sat_load: got %0d want 8", counter_out); end
    en = 1'b1; tick();
    tests_run++;
    if (counter_out !== 4'd9 || tc_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_hit: got %0d tc=%b ovf=%b want 9 1 1", counter_out, tc_pulse, ovf_sticky);
    end
    tick();
    tests_run++;
    if (counter_out !== 4'd9 || tc_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL sat_push: got %0d tc=%b want 9 1", counter_out, tc_pulse);
    end
    up_down = 1'b0; step = 2'd3; tick();
    tests_run++;
    if (counter_out !== 4'd6 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL sat_down: got %0d tc=%b want 6 0", counter_out, tc_pulse);
    end
    tick(); tick();
    tests_run++;
    if (counter_out !== 4'd2 || tc_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL sat_low: got %0d tc=%b want 2 1", counter_out, tc_pulse);
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    min_val = 4'd0; max_val = 4'd15; mode = 1'b0; step = 2'd2; up_down = 1'b0;
    load_val = 4'd1; load_en = 1'b1; tick(); load_en = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd15 || tc_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL down_wrap: got %0d tc=%b want 15 1", counter_out, tc_pulse);
    end
    up_down = 1'b1; step = 2'd1; en = 1'b1; tick(); en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd0 || tc_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL up_carry_wrap: got %0d tc=%b want 0 1", counter_out, tc_pulse);
    end
  endtask

  task automatic test_load();
    min_val = 4'd2; max_val = 4'd9; mode = 1'b0; up_down = 1'b1; step = 2'd1;
    load_val = 4'd14; load_en = 1'b1; tick();
    tests_run++;
    if (counter_out !== 4'd9 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL load_clamp_hi: got %0d tc=%b want 9 0", counter_out, tc_pulse);
    end
    load_val = 4'd0; tick();
    tests_run++;
    if (counter_out !== 4'd2) begin tests_failed++; $display("FAIL load_clamp_lo: got %0d want 2", counter_out); end
    load_val = 4'd9; tick();
    load_val = 4'd5; en = 1'b1; tick();
    tests_run++;
    if (counter_out !== 4'd5 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL load_over_en: got %0d tc=%b want 5 0", counter_out, tc_pulse);
    end
    load_en = 1'b0; step = 2'd0; tick(); en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd5 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL step_zero: got %0d tc=%b want 5 0", counter_out, tc_pulse);
    end
  endtask

  task automatic test_cfg_err();
    min_val = 4'd10; max_val = 4'd5; step = 2'd1; up_down = 1'b1; #1;
    tests_run++;
    if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL cfg_err: got %b want 1", cfg_err); end
    en = 1'b1; tick();
    clear = 1'b1; tick(); clear = 1'b0;
    load_val = 4'd7; load_en = 1'b1; tick(); load_en = 1'b0; en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd5 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_hold: got %0d tc=%b want 5 0", counter_out, tc_pulse);
    end
    min_val = 4'd2; max_val = 4'd9; mode = 1'b0;
    load_val = 4'd9; load_en = 1'b1; tick(); load_en = 1'b0;
    tests_run++;
    if (ovf_sticky !== 1'b1) begin tests_failed++; $display("FAIL ovf_pre: got %b want 1", ovf_sticky); end
    en = 1'b1; ovf_clr = 1'b1; tick(); en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd2 || tc_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: got %0d tc=%b ovf=%b want 2 1 1", counter_out, tc_pulse, ovf_sticky);
    end
    tick(); ovf_clr = 1'b0;
    tests_run++;
    if (ovf_sticky !== 1'b0 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_clr_alone: ovf=%b tc=%b want 0 0", ovf_sticky, tc_pulse);
    end
  endtask

  task automatic test_reset_mid();
    min_val = 4'd2; max_val = 4'd9; mode = 1'b0; up_down = 1'b1; step = 2'd1;
    load_val = 4'd9; load_en = 1'b1; tick(); load_en = 1'b0;
    en = 1'b1; tick();
    load_val = 4'd6; load_en = 1'b1; tick(); load_en = 1'b0;
    tick();
    tests_run++;
    if (counter_out !== 4'd7 || ovf_sticky !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset: got %0d ovf=%b want 7 1", counter_out, ovf_sticky);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (counter_out !== 4'd0 || tc_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %0d tc=%b ovf=%b want 0 0 0", counter_out, tc_pulse, ovf_sticky);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (counter_out !== 4'd2 || tc_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL snap_up: got %0d tc=%b want 2 0", counter_out, tc_pulse);
    end
    min_val = 4'd5; up_down = 1'b0; tick(); en = 1'b0;
    tests_run++;
    if (counter_out !== 4'd9 || tc_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL snap_down: got %0d tc=%b ovf=%b want 9 0 0", counter_out, tc_pulse, ovf_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_saturate();
    test_down_wrap();
    test_load();
    test_cfg_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_counter_updown_bounded_nbit
